quad_decoder8b: RTL and testbench

Quadrature decoder that turns two phase-shifted encoder inputs (A, B) into an 8-bit up/down position count. Each input is synchronised and glitch-filtered, and each legal Gray-code phase step is decoded as one count step (x4 decoding). It sits on the input side of the counter datapath: its `dir` and `step` outputs use the same up/down convention as the existing 8-bit up/down counter (`dir`=1 means up), and it also keeps its own position register.

---
 rtl/quad_decoder8b_pkg.sv | 30 +++
 rtl/quad_decoder8b_sync_filter2b.sv | 55 +++++
 rtl/quad_decoder8b.sv | 114 +++++++++++
 tb/tb_quad_decoder8b.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/quad_decoder8b_pkg.sv
// Shared phase/state encodings and helpers for the quadrature decoder.
// Holds the default filter depth and the up-sequence successor function.
package quad_decoder8b_pkg;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   localparam int FILT_DEF = 2;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_e;

   // Successor of a phase in the up sequence 00->01->11->10->00.
   function automatic logic [1:0] ph_next_up(input logic [1:0] ph);
      logic [1:0] nx;
      nx = PH_00;
      unique case (ph)
         PH_00: nx = PH_01;
         PH_01: nx = PH_11;
         PH_11: nx = PH_10;
         PH_10: nx = PH_00;
      endcase
      return nx;
   endfunction

endpackage

// File: rtl/quad_decoder8b_sync_filter2b.sv
// 2-bit two-flop synchroniser followed by a stability-count glitch filter.
// Ports: clk, reset (async, active low), d_in (raw pair), f (filtered), busy.
module sync_filter2b
   import quad_decoder8b_pkg::*;
#(
   parameter int FILT = FILT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] d_in,
   output logic [1:0] f,
   output logic       busy
);

   logic [1:0] m_q;
   logic [1:0] s_q;
   logic [1:0] f_q;
   logic [1:0] f_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // A pending change in the sync chain restarts the count, so a new
   // level must sit unchanged on s_q for FILT edges before it is taken.
   always_comb begin
      f_d   = f_q;
      cnt_d = '0;
      if (m_q != s_q) begin
         cnt_d = '0;
      end else if (s_q != f_q) begin
         if (cnt_q == 4'(FILT - 1)) begin
            f_d = s_q;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q   <= '0;
         s_q   <= '0;
         f_q   <= '0;
         cnt_q <= '0;
      end else begin
         m_q   <= d_in;
         s_q   <= m_q;
         f_q   <= f_d;
         cnt_q <= cnt_d;
      end
   end

   assign f    = f_q;
   assign busy = (m_q != s_q) || (s_q != f_q);

endmodule

// File: rtl/quad_decoder8b.sv
// x4 quadrature decoder: filtered A/B phase tracking into an up/down count.
// Ports: clk, reset (async low), a_in, b_in, clr -> count, dir, step, err.
module quad_decoder8b
   import quad_decoder8b_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int FILT  = FILT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             step,
   output logic             err
);

   // INIT waits until a level present at reset release has had time to
   // pass the synchroniser and the filter before it becomes the reference.
   localparam logic [4:0] INIT_WAIT = 5'(FILT + 2);

   logic [1:0]       ph_f;
   logic             f_busy;

   state_e           state_q, state_d;
   logic [4:0]       init_q, init_d;
   logic [1:0]       ref_q, ref_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;

   sync_filter2b #(
      .FILT (FILT)
   ) u_filt (
      .clk   (clk),
      .reset (reset),
      .d_in  ({a_in, b_in}),
      .f     (ph_f),
      .busy  (f_busy)
   );

   always_comb begin
      state_d = state_q;
      init_d  = init_q;
      ref_d   = ref_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         ST_INIT: begin
            if (init_q != INIT_WAIT) begin
               init_d = init_q + 5'd1;
            end else if (!f_busy) begin
               ref_d   = ph_f;
               state_d = ST_TRACK;
            end
         end
         ST_TRACK: begin
            if (ph_f != ref_q) begin
               // An illegal jump still becomes the new reference.
               ref_d = ph_f;
               unique case (1'b1)
                  (ph_next_up(ref_q) == ph_f): begin
                     cnt_d  = cnt_q + WIDTH'(1);
                     dir_d  = 1'b1;
                     step_d = 1'b1;
                  end
                  (ph_next_up(ph_f) == ref_q): begin
                     cnt_d  = cnt_q - WIDTH'(1);
                     dir_d  = 1'b0;
                     step_d = 1'b1;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
      endcase
      if (clr) begin
         cnt_d  = '0;
         err_d  = 1'b0;
         step_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_INIT;
         init_q  <= '0;
         ref_q   <= PH_00;
         cnt_q   <= '0;
         dir_q   <= 1'b1;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q  <= init_d;
         ref_q   <= ref_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         err_q   <= err_d;
      end
   end

   assign count = cnt_q;
   assign dir   = dir_q;
   assign step  = step_q;
   assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder8b.sv
// Directed bench for quad_decoder8b at WIDTH=8, FILT=2.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_quad_decoder8b;

   logic       clk;
   logic       reset;
   logic       a_in;
   logic       b_in;
   logic       clr;
   logic [7:0] count;
   logic       dir;
   logic       step;
   logic       err;

   int n_vec;
   int n_bad;
   int steps;
   int dbl;
   logic step_prev;

   // Input set at a falling edge is first sampled one posedge later; the
   // step appears at the 5th posedge, read at the negedge that follows it.
   localparam int LAT = 5;

   quad_decoder8b #(
      .WIDTH (8),
      .FILT  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .a_in  (a_in),
      .b_in  (b_in),
      .clr   (clr),
      .count (count),
      .dir   (dir),
      .step  (step),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (step) steps++;
      if (step && step_prev) dbl++;
      step_prev = step;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic move(input logic [1:0] ph, output int lat);
      lat = -1;
      {a_in, b_in} = ph;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (step && lat < 0) lat = i;
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
   endtask

   logic [1:0] up_seq [4];
   int lat;
   int s0;

   initial begin
      n_vec = 0;
      n_bad = 0;
      steps = 0;
      dbl = 0;
      step_prev = 1'b0;
      up_seq[0] = 2'b01;
      up_seq[1] = 2'b11;
      up_seq[2] = 2'b10;
      up_seq[3] = 2'b00;
      reset = 1'b0;
      a_in = 1'b0;
      b_in = 1'b0;
      clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_count", 32'(count), 32'h0);
      check("rst_dir", 32'(dir), 32'h1);
      check("rst_step", 32'(step), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check("init_nostep", 32'(steps), 32'd0);

      // Forward: 8 up steps
      s0 = steps;
      for (int k = 0; k < 8; k++) begin
         move(up_seq[k % 4], lat);
         check($sformatf("fwd_lat%0d", k), 32'(lat), 32'(LAT));
      end
      check("fwd_count", 32'(count), 32'd8);
      check("fwd_dir", 32'(dir), 32'h1);
      check("fwd_steps", 32'(steps - s0), 32'd8);
      check("fwd_dbl", 32'(dbl), 32'd0);

      // Reverse wrap
      pulse_clr();
      check("clr_count", 32'(count), 32'd0);
      move(2'b10, lat);
      check("wrap_dn_count", 32'(count), 32'd255);
      check("wrap_dn_dir", 32'(dir), 32'h0);
      move(2'b00, lat);
      check("wrap_up_count", 32'(count), 32'd0);
      check("wrap_up_dir", 32'(dir), 32'h1);

      // Glitch: 1-cycle pulse discarded, 3-cycle pulse gives two steps
      s0 = steps;
      a_in = 1'b1;
      @(negedge clk);
      a_in = 1'b0;
      repeat (10) @(negedge clk);
      check("gl1_steps", 32'(steps - s0), 32'd0);
      check("gl1_count", 32'(count), 32'd0);
      s0 = steps;
      a_in = 1'b1;
      repeat (3) @(negedge clk);
      a_in = 1'b0;
      repeat (12) @(negedge clk);
      check("gl3_steps", 32'(steps - s0), 32'd2);
      check("gl3_count", 32'(count), 32'd0);
      check("gl3_dir", 32'(dir), 32'h1);
      check("gl3_dbl", 32'(dbl), 32'd0);

      // Illegal jump, recovery, clr, clr against a step
      s0 = steps;
      move(2'b11, lat);
      check("ill_err", 32'(err), 32'h1);
      check("ill_count", 32'(count), 32'd0);
      check("ill_steps", 32'(steps - s0), 32'd0);
      move(2'b10, lat);
      check("ill_next_count", 32'(count), 32'd1);
      check("ill_next_err", 32'(err), 32'h1);
      pulse_clr();
      check("clr2_count", 32'(count), 32'd0);
      check("clr2_err", 32'(err), 32'h0);
      move(2'b00, lat);
      check("pre_clr_count", 32'(count), 32'd1);
      s0 = steps;
      {a_in, b_in} = 2'b01;
      repeat (4) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (5) @(negedge clk);
      check("clrstep_steps", 32'(steps - s0), 32'd0);
      check("clrstep_count", 32'(count), 32'd0);
      move(2'b00, lat);
      check("clrstep_dn", 32'(count), 32'd255);
      pulse_clr();

      // Reset mid-run: reach 0x37 with dir=0 and err=1
      for (int k = 0; k < 56; k++) move(up_seq[k % 4], lat);
      move(2'b10, lat);
      move(2'b01, lat);
      check("mid_count", 32'(count), 32'h37);
      check("mid_dir", 32'(dir), 32'h0);
      check("mid_err", 32'(err), 32'h1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("arst_count", 32'(count), 32'h0);
      check("arst_dir", 32'(dir), 32'h1);
      check("arst_err", 32'(err), 32'h0);
      check("arst_step", 32'(step), 32'h0);
      {a_in, b_in} = 2'b11;
      repeat (3) @(negedge clk);
      s0 = steps;
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check("rel_steps", 32'(steps - s0), 32'd0);
      check("rel_count", 32'(count), 32'd0);
      move(2'b10, lat);
      check("rel_up_count", 32'(count), 32'd1);
      check("rel_up_dir", 32'(dir), 32'h1);
      check("rel_up_lat", 32'(lat), 32'(LAT));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
